// File: rtl/output_uart_tx_pkg.sv
// Shared types and constants for the output_uart_tx block: word layout and the UART FSM encoding.
package output_uart_tx_pkg;

    localparam int unsigned DATA_WIDTH = 16;
    localparam int unsigned BYTE_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    typedef logic [BYTE_WIDTH-1:0] byte_t;

    // Processor output word; the high byte goes out on the line first.
    typedef struct packed {
        byte_t hi;
        byte_t lo;
    } word_t;

    function automatic byte_t sel_byte(input word_t w, input logic hi);
        return hi ? w.hi : w.lo;
    endfunction

endpackage

// File: rtl/output_uart_tx_if.sv
// Word-stream and status bundle between the processor-side producer and the UART TX sink.
interface output_uart_tx_if #(
    parameter int unsigned FIFO_DEPTH = 8
) ();
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic                        in_valid;
    output_uart_tx_pkg::word_t   in_data;
    logic                        clear_overflow;
    logic                        uart_tx;
    logic                        tx_busy;
    logic [CNT_W-1:0]            fifo_count;
    logic                        overflow;

    modport master (
        output in_valid, in_data, clear_overflow,
        input  uart_tx, tx_busy, fifo_count, overflow
    );

    modport slave (
        input  in_valid, in_data, clear_overflow,
        output uart_tx, tx_busy, fifo_count, overflow
    );

endinterface

// File: rtl/output_uart_tx_out_fifo.sv
// Synchronous first-word-fall-through FIFO; a write into a full FIFO succeeds when a read happens in the same cycle.
module out_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_c;
    logic             pop_c;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign pop_c   = rd_en & ~empty;
    assign push_c  = wr_en & (~full | pop_c);
    assign rd_data = mem[rd_ptr];

    // Storage array carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_c, pop_c})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/output_uart_tx.sv
// Buffers processor output words and serialises each as two 8N1 UART frames, high byte first.
module output_uart_tx
    import output_uart_tx_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic               clk,
    input  logic               reset_n,
    output_uart_tx_if.slave    bus
);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

    tx_state_e          state, state_d;
    logic [BAUD_W-1:0]  baud, baud_d;
    logic [2:0]         bit_idx, bit_d;
    byte_t              shift, shift_d;
    word_t              hold, hold_d;
    logic               hi, hi_d;
    logic               tx_d;

    logic               pop_c;
    logic               drop_c;
    logic               baud_end_c;
    word_t              fifo_rd_data;
    logic [CNT_W-1:0]   fifo_cnt;
    logic               fifo_full;
    logic               fifo_empty;

    out_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (bus.in_valid),
        .wr_data (bus.in_data),
        .rd_en   (pop_c),
        .rd_data (fifo_rd_data),
        .count   (fifo_cnt),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign bus.fifo_count = fifo_cnt;
    assign baud_end_c     = (baud == BAUD_W'(CLKS_PER_BIT - 1));
    assign drop_c         = bus.in_valid & fifo_full & ~pop_c;

    // Next-state, datapath and line-level decode.
    always_comb begin
        state_d = state;
        baud_d  = baud;
        bit_d   = bit_idx;
        shift_d = shift;
        hold_d  = hold;
        hi_d    = hi;
        pop_c   = 1'b0;
        tx_d    = 1'b1;

        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop_c   = 1'b1;
                    hold_d  = fifo_rd_data;
                    hi_d    = 1'b1;
                    shift_d = sel_byte(fifo_rd_data, 1'b1);
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (baud_end_c) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    baud_d  = baud + BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (baud_end_c) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift[BYTE_WIDTH-1:1]};
                    if (bit_idx == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d   = bit_idx + 3'd1;
                    end
                end else begin
                    baud_d  = baud + BAUD_W'(1);
                end
            end
            ST_STOP: begin
                if (baud_end_c) begin
                    baud_d = '0;
                    if (hi) begin
                        hi_d    = 1'b0;
                        shift_d = sel_byte(hold, hi_d);
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d  = baud + BAUD_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Line value is decoded from next state so uart_tx comes straight off a flop.
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            hold    <= '0;
            hi      <= 1'b0;
        end else begin
            state   <= state_d;
            baud    <= baud_d;
            bit_idx <= bit_d;
            shift   <= shift_d;
            hold    <= hold_d;
            hi      <= hi_d;
        end
    end

    // Registered status outputs; a drop wins over a same-cycle clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.uart_tx  <= 1'b1;
            bus.tx_busy  <= 1'b0;
            bus.overflow <= 1'b0;
        end else begin
            bus.uart_tx  <= tx_d;
            bus.tx_busy  <= (state != ST_IDLE) | ~fifo_empty;
            if (drop_c) begin
                bus.overflow <= 1'b1;
            end else if (bus.clear_overflow) begin
                bus.overflow <= 1'b0;
            end
        end
    end

endmodule
